// File: rtl/dp_ram_arbiter.sv
// Access controller for the dual-port RAM: one write client, NUM_RD round-robin read clients,
// with a stall counter that forces a read slot when continuous writes starve the readers.
module dp_ram_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int NUM_RD    = 2,
    parameter int MAX_STALL = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_valid,
    input  logic [AW-1:0]          w_addr,
    input  logic [WIDTH-1:0]       w_data,
    output logic                   w_ready,
    input  logic [NUM_RD-1:0]      r_valid,
    input  logic [NUM_RD*AW-1:0]   r_addr,
    output logic [NUM_RD-1:0]      r_ready,
    output logic [NUM_RD-1:0]      r_rvalid,
    output logic [WIDTH-1:0]       r_rdata,
    output logic                   ram_wr,
    output logic [AW-1:0]          ram_waddr,
    output logic [WIDTH-1:0]       ram_din,
    output logic                   ram_rd,
    output logic [AW-1:0]          ram_raddr,
    input  logic [WIDTH-1:0]       ram_dout
);

    localparam int PW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int SW = $clog2(MAX_STALL + 1);

    logic [PW-1:0]     ptr, ptr_nxt, win, idx;
    logic              found;
    int                idx_i;
    logic [SW-1:0]     stall_cnt, stall_nxt;
    logic              force_rd, force_nxt;
    logic [NUM_RD-1:0] grant;
    logic [NUM_RD-1:0] rvalid_p1;
    logic [AW-1:0]     addr_arr [NUM_RD];

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            addr_arr[i] = r_addr[i*AW +: AW];
        end
    end

    // Write path: the writer only yields when a read is being forced.
    assign w_ready   = !force_rd && rst_n;
    assign ram_wr    = w_valid && w_ready;
    assign ram_waddr = w_addr;
    assign ram_din   = w_data;

    // Round-robin search starting at ptr; first requesting client wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        idx_i = 0;
        for (int k = 0; k < NUM_RD; k++) begin
            idx_i = (int'(ptr) + k) % NUM_RD;
            idx   = PW'(idx_i);
            if (!found && r_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && !ram_wr && rst_n) begin
            grant[win] = 1'b1;
        end
    end

    assign r_ready   = grant;
    assign ram_rd    = |grant;
    assign ram_raddr = addr_arr[win];

    always_comb begin
        ptr_nxt = ptr;
        if (|grant) begin
            ptr_nxt = (int'(win) == NUM_RD - 1) ? '0 : win + 1'b1;
        end

        stall_nxt = stall_cnt;
        if ((|grant) || (r_valid == '0)) begin
            stall_nxt = '0;
        end else if (ram_wr) begin
            stall_nxt = stall_cnt + 1'b1;
        end

        // One blocked write cycle per starvation event, released after the forced grant.
        if (force_rd) begin
            force_nxt = !(|grant) && (|r_valid);
        end else begin
            force_nxt = (|r_valid) && (stall_nxt == SW'(MAX_STALL));
        end
    end

    // Stage boundary: arbitration state and the grant-to-response register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            stall_cnt <= '0;
            force_rd  <= 1'b0;
            rvalid_p1 <= '0;
        end else begin
            ptr       <= ptr_nxt;
            stall_cnt <= stall_nxt;
            force_rd  <= force_nxt;
            rvalid_p1 <= grant;
        end
    end

    // Gated so a grant issued just before reset never surfaces as a response.
    assign r_rvalid = rst_n ? rvalid_p1 : '0;
    assign r_rdata  = ram_dout;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Self-checking bench for dp_ram_arbiter: vector tables plus hand sequences, with a
// scoreboard of expected read responses and a shadow copy of RAM contents.
module tb_dp_ram_arbiter;

    localparam int WIDTH = 8;
    localparam int AW    = 10;
    localparam logic [AW-1:0] RA0 = 10'd3;
    localparam logic [AW-1:0] RA1 = 10'd10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             w_valid;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic             w_ready;
    logic [1:0]       r_valid;
    logic [2*AW-1:0]  r_addr;
    logic [1:0]       r_ready;
    logic [1:0]       r_rvalid;
    logic [WIDTH-1:0] r_rdata;
    logic             ram_wr;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_din;
    logic             ram_rd;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_dout = '0;

    logic [WIDTH-1:0] mem    [0:1023] = '{default: 8'h00};
    logic [WIDTH-1:0] shadow [0:1023] = '{default: 8'h00};

    dp_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(1024), .NUM_RD(2), .MAX_STALL(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
        .r_valid(r_valid), .r_addr(r_addr), .r_ready(r_ready),
        .r_rvalid(r_rvalid), .r_rdata(r_rdata),
        .ram_wr(ram_wr), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .ram_rd(ram_rd), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) mem[ram_waddr] <= ram_din;
        if (ram_rd) ram_dout <= mem[ram_raddr];
    end

    typedef struct packed {
        logic             rst;
        logic             wv;
        logic [AW-1:0]    wa;
        logic [WIDTH-1:0] wd;
        logic [1:0]       rv;
        logic             e_wrdy;
        logic [1:0]       e_rrdy;
    } vec_t;

    typedef struct packed {
        int               cyc;
        logic [1:0]       oh;
        logic [WIDTH-1:0] data;
    } sb_t;

    sb_t  sbq[$];
    vec_t tbl1[$];
    vec_t tbl2[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    function automatic vec_t mk(logic rst, logic wv, logic [AW-1:0] wa, logic [WIDTH-1:0] wd,
                                logic [1:0] rv, logic e_wrdy, logic [1:0] e_rrdy);
        vec_t v;
        v.rst = rst; v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv;
        v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [1:0]       exp_rv;
        logic [WIDTH-1:0] exp_d;
        logic [AW-1:0]    a;
        rst_n   = v.rst;
        w_valid = v.wv;
        w_addr  = v.wa;
        w_data  = v.wd;
        r_valid = v.rv;
        r_addr  = {RA1, RA0};
        @(negedge clk);
        if (!v.rst) sbq.delete();
        exp_rv = '0;
        exp_d  = '0;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            exp_rv = sbq[0].oh;
            exp_d  = sbq[0].data;
            void'(sbq.pop_front());
        end
        chk("r_rvalid", 32'(r_rvalid), 32'(exp_rv));
        if (exp_rv != 2'b00) chk("r_rdata", 32'(r_rdata), 32'(exp_d));
        chk("w_ready", 32'(w_ready), 32'(v.e_wrdy));
        chk("r_ready", 32'(r_ready), 32'(v.e_rrdy));
        chk("ram_wr", 32'(ram_wr), 32'(v.wv & v.e_wrdy));
        chk("ram_rd", 32'(ram_rd), 32'(|v.e_rrdy));
        if (v.wv && v.e_wrdy) begin
            chk("ram_waddr", 32'(ram_waddr), 32'(v.wa));
            chk("ram_din", 32'(ram_din), 32'(v.wd));
            shadow[v.wa] = v.wd;
        end
        if (v.e_rrdy != 2'b00) begin
            a = v.e_rrdy[1] ? RA1 : RA0;
            chk("ram_raddr", 32'(ram_raddr), 32'(a));
            sbq.push_back('{cyc: cyc + 1, oh: v.e_rrdy, data: shadow[a]});
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; w_valid = 1'b0; w_addr = '0; w_data = '0; r_valid = '0; r_addr = '0;

        //              rst  wv   wa      wd     rv     wrdy  rrdy
        tbl1.push_back(mk(0, 1, 10'd5,  8'h11, 2'b11, 0, 2'b00));
        tbl1.push_back(mk(0, 1, 10'd5,  8'h11, 2'b11, 0, 2'b00));
        tbl1.push_back(mk(0, 1, 10'd5,  8'h11, 2'b11, 0, 2'b00));
        tbl1.push_back(mk(1, 0, 10'd0,  8'h00, 2'b11, 1, 2'b01));
        tbl1.push_back(mk(1, 1, 10'd10, 8'h5A, 2'b10, 1, 2'b00));
        tbl1.push_back(mk(1, 0, 10'd0,  8'h00, 2'b10, 1, 2'b10));
        tbl1.push_back(mk(1, 0, 10'd0,  8'h00, 2'b11, 1, 2'b01));
        tbl1.push_back(mk(1, 0, 10'd0,  8'h00, 2'b11, 1, 2'b10));
        tbl1.push_back(mk(1, 0, 10'd0,  8'h00, 2'b11, 1, 2'b01));
        tbl1.push_back(mk(1, 0, 10'd0,  8'h00, 2'b10, 1, 2'b10));
        tbl1.push_back(mk(1, 1, 10'd3,  8'hC3, 2'b01, 1, 2'b00));
        tbl1.push_back(mk(1, 0, 10'd0,  8'h00, 2'b01, 1, 2'b01));
        tbl1.push_back(mk(1, 0, 10'd0,  8'h00, 2'b00, 1, 2'b00));

        tbl2.push_back(mk(1, 0, 10'd0,  8'h00, 2'b00, 1, 2'b00));
        tbl2.push_back(mk(1, 0, 10'd0,  8'h00, 2'b10, 1, 2'b10));
        tbl2.push_back(mk(0, 1, 10'd7,  8'h77, 2'b00, 0, 2'b00));
        tbl2.push_back(mk(1, 0, 10'd0,  8'h00, 2'b01, 1, 2'b01));
        tbl2.push_back(mk(0, 1, 10'd7,  8'h77, 2'b00, 0, 2'b00));
        tbl2.push_back(mk(1, 0, 10'd0,  8'h00, 2'b11, 1, 2'b01));
        tbl2.push_back(mk(1, 0, 10'd0,  8'h00, 2'b10, 1, 2'b10));
        tbl2.push_back(mk(1, 0, 10'd0,  8'h00, 2'b00, 1, 2'b00));
        tbl2.push_back(mk(1, 0, 10'd0,  8'h00, 2'b00, 1, 2'b00));

        @(posedge clk);
        #1;

        // Reset, write-then-read, round-robin, write blocking a read.
        for (int i = 0; i < tbl1.size(); i++) apply(tbl1[i]);

        // Starvation: continuous writer with client 0 waiting; every fifth cycle is a forced read.
        for (int k = 0; k < 15; k++) begin
            if (k % 5 == 4)
                apply(mk(1, 1, 10'(20 + k), 8'(k * 7 + 1), 2'b01, 0, 2'b01));
            else
                apply(mk(1, 1, 10'(20 + k), 8'(k * 7 + 1), 2'b01, 1, 2'b00));
        end

        // Reset during a pending response; ptr must restart at client 0.
        for (int i = 0; i < tbl2.size(); i++) apply(tbl2[i]);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
